mel_frame_sched: RTL and testbench
==================================

// Module: mel_frame_sched
// PURPOSE
//  Frame-level scheduler for the Mel spectrogram pipeline (STFT -> MEL_FBANK).
//  - Gates the STFT data-enable for exactly n_frames frames.
//  - Generates the per-beat FFT bin index and counts power-spectrum bins.
//  - Converts MEL_FBANK output beats into linear spectrogram-buffer writes, address frame*MEL_BANDS+band.
//  - Reports done, overrun and timeout.
// PARAMETERS
//  WIDTH        16    mel sample width
//  N_FFT        512   FFT size; N_BINS = N_FFT/2+1 bins per frame
//  MEL_BANDS    40    mel bands per frame
//  N_FRAMES     101   max frames; default when cfg_n_frames==0
//  WDOG_CYCLES  4096  stall limit in cycles (used only with MEL_SCHED_WDOG_EN)
//  derived: BIN_W=$clog2(N_BINS), FRAME_W=$clog2(N_FRAMES+1), SPEC_ADDR_WIDTH=$clog2(N_FRAMES*MEL_BANDS)
// PORTS
//  clk           in  1                single clock, rising edge
//  rst_n         in  1                synchronous active-low reset
//  cfg_start     in  1                pulse: begin a spectrogram run
//  cfg_abort     in  1                pulse: abandon the current run
//  cfg_n_frames  in  FRAME_W          frame count; 0 means N_FRAMES; values >N_FRAMES clamp to N_FRAMES
//  stft_den      out 1                data enable to STFT
//  pwd_odata_en  in  1                STFT power-bin valid
//  fft_bin_idx   out BIN_W            index of the current bin beat
//  mel_avail     in  1                MEL_FBANK output valid
//  mel_data      in  WIDTH            MEL_FBANK output value
//  spec_we       out 1                spectrogram buffer write strobe
//  spec_addr     out SPEC_ADDR_WIDTH  write address
//  spec_wdata    out WIDTH            write data
//  busy          out 1                high in RUN or DRAIN
//  done          out 1                one-cycle pulse at end of run
//  err_overrun   out 1                sticky: unexpected mel beat
//  err_timeout   out 1                sticky: watchdog expired
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; all counters 0.
//  FSM:
//  - IDLE: cfg_start latches n_frames, clears counters and both err flags, -> RUN.
//  - RUN: stft_den=1. Each pwd_odata_en beat advances the bin counter, wrapping at N_BINS-1.
//    - A wrap increments bin_frame.
//    - When the wrap beat completes frame n_frames -> DRAIN; stft_den=0 from the next cycle.
//  - DRAIN: stft_den=0. When wr_cnt reaches n_frames*MEL_BANDS -> DONE.
//  - DONE: done=1 for exactly one cycle, -> IDLE.
//  fft_bin_idx: registered count; equals the index of the beat while pwd_odata_en is high; 0 in IDLE.
//  Mel writes: accepted in RUN or DRAIN while wr_cnt < total.
//  - Registered path, 1-cycle latency: spec_we=1, spec_wdata=mel_data, spec_addr=wr_cnt.
//  - Then wr_cnt+1. Address uses an incrementer, no multiplier.
//  - Band and frame counters track band and frame for debug.
//  Boundaries:
//  - mel_avail in IDLE or DONE, or with wr_cnt==total: no write; err_overrun=1.
//  - pwd_odata_en outside RUN: ignored; the bin counter holds.
//  - cfg_abort, any state: -> IDLE next cycle; stft_den, spec_we, busy drop; no done; err flags kept.
//  - cfg_abort wins over a simultaneous cfg_start.
//  - cfg_start while busy: ignored.
//  - pwd_odata_en and mel_avail in the same cycle: both processed.
//  - The last bin beat and the last mel write may coincide; DONE still follows the write.
// CONFIGURATION
//  Macro MEL_SCHED_WDOG_EN:
//  - Defined: a stall counter runs in RUN/DRAIN and clears on any pwd_odata_en or mel_avail.
//    On reaching WDOG_CYCLES: err_timeout=1 (sticky until cfg_start), -> IDLE, no done.
//  - Undefined: no counter; err_timeout tied to 0; RUN/DRAIN wait indefinitely.
// STRUCTURE
//  Package mel_sched_pkg:
//  - state enum {IDLE,RUN,DRAIN,DONE}.
//  - Functions n_bins(N_FFT) and clamp_frames().
//  Sub-module mel_wrap_cnt (inc, max, clr -> cnt, wrap). Instanced for bins and bands.
// TESTING (N_FFT=16 -> 9 bins, MEL_BANDS=4, N_FRAMES=5)
//  1 n_frames=3, 27 bin beats, 12 mel beats.
//    -> stft_den low the cycle after the 27th bin; spec_addr 0..11 in order.
//    -> done single pulse after the 12th write; busy 0.
//  2 n_frames=0 -> 5 frames run: 45 bins, 20 writes, last spec_addr=19.
//  3 cfg_abort after 5 bins -> IDLE next cycle, no done.
//    Restart -> fft_bin_idx=0 on the first beat, first spec_addr=0.
//  4 13th mel beat after 12 writes, then an extra beat in IDLE.
//    -> no spec_we, err_overrun=1; the next cfg_start clears it.
//  5 cfg_start and cfg_abort together in IDLE -> stays IDLE, busy=0.
//    cfg_start mid-RUN -> counters unchanged.
//  6 WDOG_CYCLES=64, no beats for 64 cycles in RUN.
//    -> with macro: err_timeout=1 and IDLE.
//    -> without macro: stays RUN, err_timeout=0.

Source files
------------

// File: rtl/mel_sched_pkg.sv
// Shared types and elaboration helpers for the Mel frame scheduler.
package mel_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Power-spectrum bins per frame for a real FFT of size n_fft.
  function automatic int unsigned n_bins(input int unsigned n_fft);
    return n_fft / 2 + 1;
  endfunction

  // Requested frame count: 0 selects the maximum, larger values saturate.
  function automatic int unsigned clamp_frames(input int unsigned n,
                                               input int unsigned max_frames);
    if (n == 0 || n > max_frames) return max_frames;
    return n;
  endfunction

endpackage

// File: rtl/mel_wrap_cnt.sv
// Wrapping up-counter: counts inc pulses 0..max, wrap flags the beat that
// returns the count to zero. clr has priority over inc.
module mel_wrap_cnt
  import mel_sched_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic [W-1:0] max,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] r_cnt;

  assign wrap = inc && (r_cnt == max);
  assign cnt  = r_cnt;

  // Count register with synchronous clear and wrap at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/mel_frame_sched.sv
// Frame-level scheduler for the STFT -> MEL_FBANK pipeline: gates the STFT
// data enable, indexes FFT bins and turns mel beats into linear spectrogram
// buffer writes. Optional stall watchdog: define MEL_SCHED_WDOG_EN.
module mel_frame_sched
  import mel_sched_pkg::*;
#(
  parameter  int unsigned WIDTH           = 16,
  parameter  int unsigned N_FFT           = 512,
  parameter  int unsigned MEL_BANDS       = 40,
  parameter  int unsigned N_FRAMES        = 101,
  parameter  int unsigned WDOG_CYCLES     = 4096,
  localparam int unsigned N_BINS          = n_bins(N_FFT),
  localparam int unsigned BIN_W           = $clog2(N_BINS),
  localparam int unsigned FRAME_W         = $clog2(N_FRAMES + 1),
  localparam int unsigned SPEC_ADDR_WIDTH = $clog2(N_FRAMES * MEL_BANDS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [FRAME_W-1:0]         cfg_n_frames,
  output logic                       stft_den,
  input  logic                       pwd_odata_en,
  output logic [BIN_W-1:0]           fft_bin_idx,
  input  logic                       mel_avail,
  input  logic [WIDTH-1:0]           mel_data,
  output logic                       spec_we,
  output logic [SPEC_ADDR_WIDTH-1:0] spec_addr,
  output logic [WIDTH-1:0]           spec_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overrun,
  output logic                       err_timeout
);

  localparam int unsigned BAND_W = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;

  state_t                     r_state, w_next;
  logic [FRAME_W-1:0]         r_n_frames, r_bin_frame, r_wr_frame;
  logic [SPEC_ADDR_WIDTH-1:0] r_wr_cnt;
  logic                       r_spec_we;
  logic [SPEC_ADDR_WIDTH-1:0] r_spec_addr;
  logic [WIDTH-1:0]           r_spec_wdata;
  logic                       r_err_overrun;

  logic [BIN_W-1:0]  w_bin_cnt;
  logic [BAND_W-1:0] w_band_cnt;
  logic              w_bin_wrap, w_band_wrap;
  logic              w_busy, w_start, w_cnt_clr, w_bin_inc;
  logic              w_mel_ok, w_overrun, w_wr_full, w_last_frame, w_wdog_fire;

  assign w_busy    = (r_state == RUN) || (r_state == DRAIN);
  assign w_start   = (r_state == IDLE) && cfg_start && !cfg_abort;
  assign w_cnt_clr = !w_busy || cfg_abort || w_wdog_fire;
  assign w_bin_inc = (r_state == RUN) && pwd_odata_en;

  // wr_cnt == n_frames*MEL_BANDS expressed through the frame/band split, so
  // no multiplier is needed (band is necessarily 0 once the last frame closes).
  assign w_wr_full    = (r_wr_frame == r_n_frames) && (w_band_cnt == '0);
  assign w_mel_ok     = w_busy && mel_avail && !w_wr_full && !cfg_abort;
  assign w_overrun    = mel_avail && !cfg_abort && !w_mel_ok;
  assign w_last_frame = w_bin_wrap && ((r_bin_frame + FRAME_W'(1)) == r_n_frames);

  mel_wrap_cnt #(.W(BIN_W)) u_bin_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bin_inc),
    .max   (BIN_W'(N_BINS - 1)),
    .clr   (w_cnt_clr),
    .cnt   (w_bin_cnt),
    .wrap  (w_bin_wrap)
  );

  mel_wrap_cnt #(.W(BAND_W)) u_band_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_mel_ok),
    .max   (BAND_W'(MEL_BANDS - 1)),
    .clr   (w_cnt_clr),
    .cnt   (w_band_cnt),
    .wrap  (w_band_wrap)
  );

`ifdef MEL_SCHED_WDOG_EN
  localparam int unsigned STALL_W = $clog2(WDOG_CYCLES + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_err_timeout;

  // Fires on the WDOG_CYCLES-th consecutive busy cycle without any beat.
  assign w_wdog_fire = w_busy && !pwd_odata_en && !mel_avail &&
                       (r_stall == STALL_W'(WDOG_CYCLES - 1));

  // Stall counter: runs while busy, restarts on any input beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (!w_busy || pwd_odata_en || mel_avail) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_wdog_fire && !cfg_abort) begin
      r_err_timeout <= 1'b1;
    end else if (w_start) begin
      r_err_timeout <= 1'b0;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_wdog_fire = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort and watchdog take priority over progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = RUN;
      RUN: begin
        if (cfg_abort || w_wdog_fire) w_next = IDLE;
        else if (w_last_frame)        w_next = DRAIN;
      end
      DRAIN: begin
        if (cfg_abort || w_wdog_fire) w_next = IDLE;
        else if (w_wr_full)           w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame count latched on start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_frames <= '0;
    end else if (w_start) begin
      r_n_frames <= FRAME_W'(clamp_frames(32'(cfg_n_frames), N_FRAMES));
    end
  end

  // Bin-frame, write-frame and write-address counters.
  always_ff @(posedge clk) begin
    if (!rst_n || w_cnt_clr) begin
      r_bin_frame <= '0;
      r_wr_frame  <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (w_bin_wrap)  r_bin_frame <= r_bin_frame + FRAME_W'(1);
      if (w_band_wrap) r_wr_frame  <= r_wr_frame + FRAME_W'(1);
      if (w_mel_ok)    r_wr_cnt    <= r_wr_cnt + SPEC_ADDR_WIDTH'(1);
    end
  end

  // Registered spectrogram write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spec_we    <= 1'b0;
      r_spec_addr  <= '0;
      r_spec_wdata <= '0;
    end else begin
      r_spec_we <= w_mel_ok;
      if (w_mel_ok) begin
        r_spec_addr  <= r_wr_cnt;
        r_spec_wdata <= mel_data;
      end
    end
  end

  // Sticky overrun flag; a stray beat in the same cycle as start still sets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_overrun <= 1'b0;
    end else if (w_overrun) begin
      r_err_overrun <= 1'b1;
    end else if (w_start) begin
      r_err_overrun <= 1'b0;
    end
  end

  assign stft_den    = (r_state == RUN);
  assign busy        = w_busy;
  assign done        = (r_state == DONE);
  assign fft_bin_idx = w_bin_cnt;
  assign spec_we     = r_spec_we;
  assign spec_addr   = r_spec_addr;
  assign spec_wdata  = r_spec_wdata;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_mel_frame_sched.sv
// Scoreboard bench for mel_frame_sched (N_FFT=16, MEL_BANDS=4, N_FRAMES=5).
module tb_mel_frame_sched;

  localparam int NB     = 9;
  localparam int NBANDS = 4;
  localparam int NFR    = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [2:0]  cfg_n_frames = '0;
  logic        pwd_odata_en = 1'b0;
  logic        mel_avail = 1'b0;
  logic [15:0] mel_data = '0;
  logic        stft_den, spec_we, busy, done, err_overrun, err_timeout;
  logic [3:0]  fft_bin_idx;
  logic [4:0]  spec_addr;
  logic [15:0] spec_wdata;

  mel_frame_sched #(
    .WIDTH       (16),
    .N_FFT       (16),
    .MEL_BANDS   (NBANDS),
    .N_FRAMES    (NFR),
    .WDOG_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_n_frames (cfg_n_frames),
    .stft_den     (stft_den),
    .pwd_odata_en (pwd_odata_en),
    .fft_bin_idx  (fft_bin_idx),
    .mel_avail    (mel_avail),
    .mel_data     (mel_data),
    .spec_we      (spec_we),
    .spec_addr    (spec_addr),
    .spec_wdata   (spec_wdata),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_we_cyc = -1;
  int  run_we = 0;
  int  n_done = 0;

  // Reference model of the current run.
  int  m_frames, bins_total, bins_sent, mel_total, mel_sent;
  bit  run_active = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every write the DUT presents must match the next expected one.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) n_done++;
    if (spec_we === 1'b1) begin
      run_we++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write at addr %0d, expected no write", spec_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("spec_addr", int'(spec_addr), e.addr);
        chk("spec_wdata", int'(spec_wdata), e.data);
      end
    end
  end

  task automatic start_run(input int n);
    cfg_n_frames = 3'(n);
    cfg_start    = 1'b1;
    tick();
    cfg_start  = 1'b0;
    m_frames   = (n == 0 || n > NFR) ? NFR : n;
    bins_total = m_frames * NB;
    mel_total  = m_frames * NBANDS;
    bins_sent  = 0;
    mel_sent   = 0;
    run_active = 1'b1;
    run_we     = 0;
    chk("start_busy", int'(busy), 1);
    chk("start_stft_den", int'(stft_den), 1);
    chk("start_overrun_clr", int'(err_overrun), 0);
    chk("start_timeout_clr", int'(err_timeout), 0);
  endtask

  // One cycle of stimulus: optional bin beat and/or mel beat.
  task automatic step(input bit p, input bit m);
    bit  acc;
    wr_t w;
    acc = run_active && (mel_sent < mel_total);
    pwd_odata_en = p;
    mel_avail    = m;
    if (p) begin
      chk("bin_idx", int'(fft_bin_idx), bins_sent % NB);
      chk("stft_den_run", int'(stft_den), 1);
    end
    if (m) begin
      mel_data = 16'($urandom);
      if (acc) begin
        w.addr = mel_sent;
        w.data = int'(mel_data);
        exp_q.push_back(w);
        mel_sent++;
      end
    end
    tick();
    pwd_odata_en = 1'b0;
    mel_avail    = 1'b0;
    if (p) begin
      bins_sent++;
      if (bins_sent == bins_total) chk("stft_den_drop", int'(stft_den), 0);
    end
    if (m && !acc) chk("overrun_set", int'(err_overrun), 1);
  endtask

  // mode 0: random interleave; 1: extra mel beat after all writes, before the
  // last bins; 2: last bin beat and last mel beat in the same cycle.
  task automatic finish_run(input int mode);
    int guard;
    bit ov_sent;
    bit found;
    bit p, m;
    guard   = 0;
    ov_sent = 1'b0;
    while ((bins_sent < bins_total || mel_sent < mel_total || (mode == 1 && !ov_sent))
           && guard < 3000) begin
      guard++;
      p = (bins_sent < bins_total) && ($urandom_range(0, 1) == 1);
      m = (mel_sent < mel_total) && ($urandom_range(0, 2) != 0);
      if (mode == 1 && !ov_sent) begin
        p = 1'b0;
        if (mel_sent == mel_total) begin
          m       = 1'b1;
          ov_sent = 1'b1;
        end
      end
      if (mode == 2) begin
        if (bins_sent == bins_total - 1 && mel_sent < mel_total - 1) p = 1'b0;
        if (mel_sent == mel_total - 1 && bins_sent < bins_total - 1) m = 1'b0;
        if (bins_sent == bins_total - 1 && mel_sent == mel_total - 1) begin
          p = 1'b1;
          m = 1'b1;
        end
      end
      step(p, m);
    end
    chk("stimulus_guard", int'(guard < 3000), 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (done === 1'b1) found = 1'b1;
    end
    chk("done_seen", int'(found), 1);
    chk("done_after_last_write", int'(cyc > last_we_cyc), 1);
    chk("write_count", run_we, mel_total);
    tick();
    chk("done_single_pulse", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    run_active = 1'b0;
  endtask

  initial begin
    int d;
    // Reset
    repeat (3) tick();
    chk("rst_stft_den", int'(stft_den), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_spec_we", int'(spec_we), 0);
    chk("rst_spec_addr", int'(spec_addr), 0);
    chk("rst_spec_wdata", int'(spec_wdata), 0);
    chk("rst_bin_idx", int'(fft_bin_idx), 0);
    chk("rst_overrun", int'(err_overrun), 0);
    chk("rst_timeout", int'(err_timeout), 0);
    rst_n = 1'b1;
    tick();

    // Bin beats in IDLE are ignored
    pwd_odata_en = 1'b1;
    tick();
    tick();
    pwd_odata_en = 1'b0;
    chk("idle_bin_idx", int'(fft_bin_idx), 0);
    chk("idle_stft_den", int'(stft_den), 0);

    // Nominal runs: 3 frames, default (0), clamped (7)
    start_run(3);
    finish_run(0);
    start_run(0);
    finish_run(0);
    start_run(7);
    finish_run(0);

    // Abort after 5 bins, then restart
    start_run(3);
    repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
    d = n_done;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    run_active = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_stft_den", int'(stft_den), 0);
    chk("abort_bin_idx", int'(fft_bin_idx), 0);
    repeat (5) tick();
    chk("abort_no_done", n_done, d);
    chk("abort_queue", exp_q.size(), 0);
    start_run(2);
    finish_run(0);

    // Overrun: extra beat in RUN after all writes, then one in IDLE
    start_run(3);
    finish_run(1);
    chk("overrun_sticky", int'(err_overrun), 1);
    step(1'b0, 1'b1);
    start_run(1);
    finish_run(0);

    // Start together with abort in IDLE
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    tick();
    chk("start_abort_busy2", int'(busy), 0);

    // Start mid-run is ignored
    start_run(2);
    repeat (3) step(1'b1, 1'b0);
    cfg_n_frames = 3'd5;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("midrun_bin_idx", int'(fft_bin_idx), 3);
    chk("midrun_busy", int'(busy), 1);
    finish_run(0);

    // Last bin and last write in the same cycle
    start_run(2);
    finish_run(2);

    // Stall of 64 cycles in RUN
    start_run(1);
    d = n_done;
    repeat (63) tick();
    chk("stall_busy_63", int'(busy), 1);
    tick();
`ifdef MEL_SCHED_WDOG_EN
    run_active = 1'b0;
    chk("wdog_busy", int'(busy), 0);
    chk("wdog_timeout", int'(err_timeout), 1);
    chk("wdog_no_done", n_done, d);
    start_run(1);
    finish_run(0);
`else
    chk("nowdog_busy", int'(busy), 1);
    chk("nowdog_timeout", int'(err_timeout), 0);
    repeat (40) tick();
    chk("nowdog_stft_den", int'(stft_den), 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    run_active = 1'b0;
    chk("nowdog_abort_busy", int'(busy), 0);
`endif

    // Random runs
    repeat (4) begin
      start_run(int'($urandom_range(0, 7)));
      finish_run(int'($urandom_range(0, 2)));
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no end of stimulus, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
